control_regs: RTL

- Parametrised, fully synchronous successor of the SPI command/control block of the thermovision FPGA.
- Receives 16-bit SPI command words (opcode in [15:8], payload in [7:0]) from the SPI receiver, which runs on its own strobe.
- Resynchronises the word-ready strobe into CLK.
- Decodes commands into widened contrast, beaten-pixel and mode registers.
- Holds mode in a shadow register and commits it to the working mode only at frame boundaries or on an explicit commit command.

---
 rtl/control_regs.sv | 336 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_regs.sv
// control_regs -- SPI command/control register block.
//
// Takes 16-bit command words (opcode [15:8], payload [7:0]) from an SPI
// receiver running on its own strobe, resynchronises the word-ready level
// into CLK, and decodes each word into contrast, beaten-pixel, enable and
// mode registers. Mode writes land in a shadow register and reach the
// working mode (MODE_FPGA) only on FRAME_END or an explicit commit opcode,
// so the pixel pipeline never sees a mode change mid-frame.
//
// Optional feature: define CTRL_READBACK_EN to enable the 0xD0 readback
// command and the SPI_DATA_OUT readback word. Without it SPI_DATA_OUT is
// tied to zero and 0xD0 counts as an unknown opcode.

module control_regs #(
  parameter int          SPI_WIDHT     = 16,
  parameter int          ADC_WIDHT     = 14,
  parameter int          MULT_WIDHT    = 5,
  parameter int          MODE_WIDTH    = 32,
  parameter logic [31:0] MODE_RESET    = 32'h000E_0D01,
  parameter int          SYNC_STAGES   = 2,
  parameter int          MODE_RGB_BIT  = 15,
  parameter int          MODE_PED_BIT  = 14,
  parameter int          MODE_BEAT_BIT = 13
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [SPI_WIDHT-1:0]  SPI_DATA,
  input  logic                  BYTE_SPI_READY,
  input  logic                  FRAME_END,
  output logic [MODE_WIDTH-1:0] MODE_FPGA,
  output logic [ADC_WIDHT-1:0]  SUB_CONTRAST,
  output logic [MULT_WIDHT-1:0] MULT_CONTRAST,
  output logic [ADC_WIDHT-1:0]  BEATEN_PIX_LEVEL,
  output logic                  BL_ENABLE,
  output logic                  CNT_ENABLE,
  output logic                  OUT_ENABLE,
  output logic                  ADC_ENABLE,
  output logic                  TEST,
  output logic                  CMD_VALID,
  output logic [7:0]            CMD_ERR_CNT,
  output logic [SPI_WIDHT-1:0]  SPI_DATA_OUT
);

  // ---------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------
  localparam logic [MODE_WIDTH-1:0] MODE_RST_VAL = MODE_RESET[MODE_WIDTH-1:0];
  localparam logic [MULT_WIDHT-1:0] MULT_RST_VAL = MULT_WIDHT'(1);
  localparam logic [ADC_WIDHT-1:0]  BEAT_RST_VAL = ADC_WIDHT'(400);

  typedef enum logic [7:0] {
    OP_EN_ALL    = 8'h10,
    OP_DIS_ALL   = 8'h20,
    OP_TEST      = 8'h30,
    OP_SUB_B0    = 8'h40,
    OP_SUB_B1    = 8'h41,
    OP_SUB_B2    = 8'h42,
    OP_MULT      = 8'h50,
    OP_PED       = 8'h60,
    OP_RGB       = 8'h70,
    OP_MODE_B0   = 8'h90,
    OP_MODE_B1   = 8'h91,
    OP_MODE_B2   = 8'h92,
    OP_MODE_B3   = 8'h93,
    OP_BEAT_B0   = 8'hB0,
    OP_BEAT_B1   = 8'hB1,
    OP_BEAT_B2   = 8'hB2,
    OP_BEAT_BIT  = 8'hB3,
    OP_COMMIT    = 8'hC0,
    OP_READBACK  = 8'hD0
  } opcode_e;

  // Fields narrower than 24/32 bits are widened to a fixed container for
  // byte access; writes into bytes beyond the real width fall off when the
  // container is truncated back, which is exactly the "accepted but
  // ignored" behaviour wanted for out-of-range byte opcodes.
  function automatic logic [23:0] put_byte24(input logic [23:0] v,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [23:0] r;
    r = v;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] put_byte32(input logic [31:0] v,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = v;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q,      sync_d;
  logic                   rdy_prev_q,  rdy_prev_d;
  logic [MODE_WIDTH-1:0]  shadow_q,    shadow_d;
  logic [MODE_WIDTH-1:0]  mode_fpga_q, mode_fpga_d;
  logic [ADC_WIDHT-1:0]   sub_q,       sub_d;
  logic [MULT_WIDHT-1:0]  mult_q,      mult_d;
  logic [ADC_WIDHT-1:0]   beat_q,      beat_d;
  logic                   bl_en_q,     bl_en_d;
  logic                   cnt_en_q,    cnt_en_d;
  logic                   out_en_q,    out_en_d;
  logic                   adc_en_q,    adc_en_d;
  logic                   test_q,      test_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [7:0]             err_cnt_q,   err_cnt_d;

  // Decode-side combinational signals
  logic        word_stb;
  opcode_e     opcode;
  logic [7:0]  payload;
  logic [1:0]  byte_idx;
  logic        commit;
  logic [23:0] sub_pad;
  logic [23:0] beat_pad;
  logic [31:0] shadow_pad;

`ifdef CTRL_READBACK_EN
  logic [3:0]           rb_idx_q,    rb_idx_d;
  logic                 rb_active_q, rb_active_d;
  logic [SPI_WIDHT-1:0] rb_word_q,   rb_word_d;
  logic [7:0]           rb_byte;
  logic [31:0]          rb_mode_pad;
  logic [31:0]          rb_shadow_pad;
  logic [23:0]          rb_sub_pad;
  logic [23:0]          rb_beat_pad;
`endif

  assign opcode   = opcode_e'(SPI_DATA[15:8]);
  assign payload  = SPI_DATA[7:0];
  assign byte_idx = SPI_DATA[9:8];

  // ---------------------------------------------------------------------
  // Ready synchroniser and rising-edge detector
  // ---------------------------------------------------------------------
  // Shift READY through the synchroniser chain; word_stb fires once per rising edge.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], BYTE_SPI_READY};
    rdy_prev_d = sync_q[SYNC_STAGES-1];
  end

  assign word_stb = sync_q[SYNC_STAGES-1] & ~rdy_prev_q;

  // ---------------------------------------------------------------------
  // Command decode and next-state computation
  // ---------------------------------------------------------------------
  // Decode the captured word and compute every register's next value.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold it.
    bl_en_d     = bl_en_q;
    cnt_en_d    = cnt_en_q;
    out_en_d    = out_en_q;
    adc_en_d    = adc_en_q;
    test_d      = test_q;
    mult_d      = mult_q;
    err_cnt_d   = err_cnt_q;
    cmd_valid_d = 1'b0;
    commit      = FRAME_END;
    sub_pad     = 24'(sub_q);
    beat_pad    = 24'(beat_q);
    shadow_pad  = 32'(shadow_q);
`ifdef CTRL_READBACK_EN
    rb_idx_d    = rb_idx_q;
    rb_active_d = rb_active_q;
`endif

    if (word_stb) begin
      cmd_valid_d = 1'b1;
      case (opcode)
        OP_EN_ALL: begin
          bl_en_d  = 1'b1;
          cnt_en_d = 1'b1;
          out_en_d = 1'b1;
          adc_en_d = 1'b1;
        end
        OP_DIS_ALL: begin
          bl_en_d  = 1'b0;
          cnt_en_d = 1'b0;
          out_en_d = 1'b0;
          adc_en_d = 1'b0;
        end
        OP_TEST:                         test_d     = payload[0];
        OP_SUB_B0, OP_SUB_B1, OP_SUB_B2: sub_pad    = put_byte24(sub_pad, byte_idx, payload);
        OP_BEAT_B0, OP_BEAT_B1, OP_BEAT_B2:
                                         beat_pad   = put_byte24(beat_pad, byte_idx, payload);
        OP_MULT:                         mult_d     = payload[MULT_WIDHT-1:0];
        OP_PED:                          shadow_pad[MODE_PED_BIT]  = payload[0];
        OP_RGB:                          shadow_pad[MODE_RGB_BIT]  = payload[0];
        OP_BEAT_BIT:                     shadow_pad[MODE_BEAT_BIT] = payload[0];
        OP_MODE_B0, OP_MODE_B1, OP_MODE_B2, OP_MODE_B3:
                                         shadow_pad = put_byte32(shadow_pad, byte_idx, payload);
        OP_COMMIT:                       commit     = 1'b1;
`ifdef CTRL_READBACK_EN
        OP_READBACK: begin
          rb_idx_d    = payload[3:0];
          rb_active_d = 1'b1;
        end
`endif
        default: begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      endcase
    end

    sub_d    = sub_pad[ADC_WIDHT-1:0];
    beat_d   = beat_pad[ADC_WIDHT-1:0];
    shadow_d = shadow_pad[MODE_WIDTH-1:0];
  end

  // Working mode takes the pre-write shadow on a commit; a same-cycle
  // shadow write therefore waits for the following commit.
  always_comb begin
    mode_fpga_d = commit ? shadow_q : mode_fpga_q;
  end

`ifdef CTRL_READBACK_EN
  // ---------------------------------------------------------------------
  // Readback mux: tracks the latched index every cycle
  // ---------------------------------------------------------------------
  // Select the readback byte from next-state values so the word stays in step with the registers.
  always_comb begin
    rb_mode_pad   = 32'(mode_fpga_d);
    rb_shadow_pad = 32'(shadow_d);
    rb_sub_pad    = 24'(sub_d);
    rb_beat_pad   = 24'(beat_d);
    case (rb_idx_d)
      4'd0:    rb_byte = rb_mode_pad[7:0];
      4'd1:    rb_byte = rb_mode_pad[15:8];
      4'd2:    rb_byte = rb_mode_pad[23:16];
      4'd3:    rb_byte = rb_mode_pad[31:24];
      4'd4:    rb_byte = rb_shadow_pad[7:0];
      4'd5:    rb_byte = rb_shadow_pad[15:8];
      4'd6:    rb_byte = rb_shadow_pad[23:16];
      4'd7:    rb_byte = rb_shadow_pad[31:24];
      4'd8:    rb_byte = rb_sub_pad[7:0];
      4'd9:    rb_byte = rb_sub_pad[15:8];
      4'd10:   rb_byte = rb_sub_pad[23:16];
      4'd11:   rb_byte = 8'(mult_d);
      4'd12:   rb_byte = rb_beat_pad[7:0];
      4'd13:   rb_byte = rb_beat_pad[15:8];
      4'd14:   rb_byte = rb_beat_pad[23:16];
      default: rb_byte = err_cnt_d;
    endcase
    rb_word_d = rb_active_d ? SPI_WIDHT'({4'hD, rb_idx_d, rb_byte}) : '0;
  end

  // Readback state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rb_idx_q    <= '0;
      rb_active_q <= 1'b0;
      rb_word_q   <= '0;
    end else begin
      rb_idx_q    <= rb_idx_d;
      rb_active_q <= rb_active_d;
      rb_word_q   <= rb_word_d;
    end
  end

  assign SPI_DATA_OUT = rb_word_q;
`else
  assign SPI_DATA_OUT = '0;
`endif

  // ---------------------------------------------------------------------
  // Register bank
  // ---------------------------------------------------------------------
  // All control state, synchronously reset; reset also drops any word in flight.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values of the others, independent of statement order.
    if (!RESET) begin
      sync_q      <= '0;
      rdy_prev_q  <= 1'b0;
      shadow_q    <= MODE_RST_VAL;
      mode_fpga_q <= MODE_RST_VAL;
      sub_q       <= '0;
      mult_q      <= MULT_RST_VAL;
      beat_q      <= BEAT_RST_VAL;
      bl_en_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      out_en_q    <= 1'b0;
      adc_en_q    <= 1'b0;
      test_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      rdy_prev_q  <= rdy_prev_d;
      shadow_q    <= shadow_d;
      mode_fpga_q <= mode_fpga_d;
      sub_q       <= sub_d;
      mult_q      <= mult_d;
      beat_q      <= beat_d;
      bl_en_q     <= bl_en_d;
      cnt_en_q    <= cnt_en_d;
      out_en_q    <= out_en_d;
      adc_en_q    <= adc_en_d;
      test_q      <= test_d;
      cmd_valid_q <= cmd_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign MODE_FPGA        = mode_fpga_q;
  assign SUB_CONTRAST     = sub_q;
  assign MULT_CONTRAST    = mult_q;
  assign BEATEN_PIX_LEVEL = beat_q;
  assign BL_ENABLE        = bl_en_q;
  assign CNT_ENABLE       = cnt_en_q;
  assign OUT_ENABLE       = out_en_q;
  assign ADC_ENABLE       = adc_en_q & ~test_q;
  assign TEST             = test_q;
  assign CMD_VALID        = cmd_valid_q;
  assign CMD_ERR_CNT      = err_cnt_q;

endmodule
